crono_timer_bank: RTL and testbench

CRONO_TIMER_BANK -- requirements
Module: crono_timer_bank

---
 rtl/crono_pkg.sv | 19 +
 rtl/crono_channel.sv | 93 +++++++++
 rtl/crono_timer_bank.sv | 74 +++++++
 tb/tb_crono_timer_bank.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crono_pkg.sv
// Shared state encoding and width helper for the countdown timer bank.
package crono_pkg;

   typedef enum logic [1:0] {
      PROG = 2'b00,
      IDLE = 2'b01,
      RUN  = 2'b10,
      DONE = 2'b11
   } crono_state_e;

   // ceil(log2(n)) with a floor of 1, so a single-entry select still gets one bit.
   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/crono_channel.sv
// One countdown channel: PROG/IDLE/RUN/DONE state machine, seconds count and ring timer.
module crono_channel
   import crono_pkg::*;
#(
   parameter int CNT_W      = 19,
   parameter int RING_TICKS = 10
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             tick_i,
   input  logic             prog_i,
   input  logic             inicio_i,
   input  logic             ack_i,
   input  logic             we_i,
   input  logic [CNT_W-1:0] value_i,
   output logic [CNT_W-1:0] count_o,
   output logic             activo_o,
   output logic             ring_o
);

   localparam int RT_W = clog2_min1(RING_TICKS + 1);

   crono_state_e     state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [RT_W-1:0]  ring_cnt_q, ring_cnt_d;
   logic             activo_q, ring_q;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      ring_cnt_d = ring_cnt_q;
      if (prog_i) begin
         state_d = PROG;
         if (state_q == PROG && we_i) count_d = value_i;
      end else begin
         case (state_q)
            PROG: begin
               // A write on the release cycle still lands and decides RUN vs IDLE.
               if (we_i) count_d = value_i;
               state_d = (inicio_i && count_d != '0) ? RUN : IDLE;
            end
            IDLE: begin
               if (inicio_i && count_q != '0) state_d = RUN;
            end
            RUN: begin
               if (!inicio_i) begin
                  state_d = IDLE;
               end else if (tick_i && count_q != '0) begin
                  count_d = count_q - CNT_W'(1);
                  if (count_q == CNT_W'(1)) begin
                     state_d    = DONE;
                     ring_cnt_d = RT_W'(RING_TICKS);
                  end
               end
            end
            DONE: begin
               if (ack_i) begin
                  state_d = IDLE;
               end else if (tick_i) begin
                  if (ring_cnt_q <= RT_W'(1)) begin
                     ring_cnt_d = '0;
                     state_d    = IDLE;
                  end else begin
                     ring_cnt_d = ring_cnt_q - RT_W'(1);
                  end
               end
            end
            default: state_d = PROG;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         state_q    <= PROG;
         count_q    <= '0;
         ring_cnt_q <= '0;
         activo_q   <= 1'b0;
         ring_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         ring_cnt_q <= ring_cnt_d;
         activo_q   <= (state_q == RUN);
         ring_q     <= (state_q == DONE);
      end
   end

   assign count_o  = count_q;
   assign activo_o = activo_q;
   assign ring_o   = ring_q;

endmodule

// File: rtl/crono_timer_bank.sv
// Bank of N_CH countdown timers sharing a one-second prescaler and a program/read bus.
module crono_timer_bank
   import crono_pkg::*;
#(
   parameter int N_CH       = 2,
   parameter int CNT_W      = 19,
   parameter int TICK_DIV   = 100_000_000,
   parameter int RING_TICKS = 10
) (
   input  logic                         clk,
   input  logic                         Reset,
   input  logic [N_CH-1:0]              ProgramarCrono,
   input  logic [N_CH-1:0]              InicioCrono,
   input  logic [N_CH-1:0]              RingAck,
   input  logic                         ProgWe,
   input  logic [clog2_min1(N_CH)-1:0]  ProgSel,
   input  logic [CNT_W-1:0]             ProgValue,
   output logic [CNT_W-1:0]             RdValue,
   output logic [N_CH-1:0]              CronoActivo,
   output logic [N_CH-1:0]              Ring
);

   localparam int SEL_W  = clog2_min1(N_CH);
   localparam int DIV_W  = clog2_min1(TICK_DIV);
   localparam int N_SLOT = 1 << SEL_W;

   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;
   logic [CNT_W-1:0] count_w [N_SLOT];
   logic [CNT_W-1:0] rd_q, rd_d;

   assign tick  = (div_q == DIV_W'(TICK_DIV - 1));
   assign div_d = tick ? '0 : div_q + DIV_W'(1);
   // Unused select codes read back as zero so the mux never indexes past the bank.
   assign rd_d  = count_w[ProgSel];

   generate
      for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_slot
         if (gi < N_CH) begin : g_ch
            crono_channel #(
               .CNT_W      (CNT_W),
               .RING_TICKS (RING_TICKS)
            ) u_ch (
               .clk      (clk),
               .Reset    (Reset),
               .tick_i   (tick),
               .prog_i   (ProgramarCrono[gi]),
               .inicio_i (InicioCrono[gi]),
               .ack_i    (RingAck[gi]),
               .we_i     (ProgWe && (ProgSel == SEL_W'(gi))),
               .value_i  (ProgValue),
               .count_o  (count_w[gi]),
               .activo_o (CronoActivo[gi]),
               .ring_o   (Ring[gi])
            );
         end else begin : g_pad
            assign count_w[gi] = '0;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!Reset) begin
         div_q <= '0;
         rd_q  <= '0;
      end else begin
         div_q <= div_d;
         rd_q  <= rd_d;
      end
   end

   assign RdValue = rd_q;

endmodule

// File: tb/tb_crono_timer_bank.sv
// Scoreboard bench for crono_timer_bank with N_CH=2, TICK_DIV=4, RING_TICKS=3.
module tb_crono_timer_bank;

   localparam int N_CH       = 2;
   localparam int CNT_W      = 19;
   localparam int TICK_DIV   = 4;
   localparam int RING_TICKS = 3;

   logic             clk = 1'b0;
   logic             Reset;
   logic [N_CH-1:0]  ProgramarCrono, InicioCrono, RingAck;
   logic             ProgWe;
   logic [0:0]       ProgSel;
   logic [CNT_W-1:0] ProgValue, RdValue;
   logic [N_CH-1:0]  CronoActivo, Ring;

   int n_chk = 0;
   int n_err = 0;
   int pcnt  = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   crono_timer_bank #(
      .N_CH       (N_CH),
      .CNT_W      (CNT_W),
      .TICK_DIV   (TICK_DIV),
      .RING_TICKS (RING_TICKS)
   ) dut (
      .clk            (clk),
      .Reset          (Reset),
      .ProgramarCrono (ProgramarCrono),
      .InicioCrono    (InicioCrono),
      .RingAck        (RingAck),
      .ProgWe         (ProgWe),
      .ProgSel        (ProgSel),
      .ProgValue      (ProgValue),
      .RdValue        (RdValue),
      .CronoActivo    (CronoActivo),
      .Ring           (Ring)
   );

   // Reference prescaler phase: a tick edge follows any cycle where pcnt == TICK_DIV-1.
   always @(posedge clk) begin
      if (!Reset) pcnt <= 0;
      else        pcnt <= (pcnt == TICK_DIV - 1) ? 0 : pcnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [31:0] obs);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_chk++;
         n_err++;
         $display("FAIL sb_underflow: got %0d, required a queued expectation", obs);
      end else begin
         e = sb_q.pop_front();
         chk(e.tag, obs, e.val);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic to_pre_tick();
      int k;
      k = 0;
      while (pcnt != TICK_DIV - 1 && k < 2 * TICK_DIV) begin
         @(negedge clk);
         k++;
      end
      if (pcnt != TICK_DIV - 1) begin
         n_chk++;
         n_err++;
         $display("FAIL tick_wait: got phase %0d, required %0d", pcnt, TICK_DIV - 1);
      end
   endtask

   task automatic to_tick();
      to_pre_tick();
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, required finish within 100000 time units");
      $fatal(1);
   end

   initial begin
      Reset = 1'b0; ProgramarCrono = 2'b11; InicioCrono = 2'b00; RingAck = 2'b00;
      ProgWe = 1'b0; ProgSel = 1'b0; ProgValue = '0;
      sb_push("rst_activo", 0); sb_push("rst_ring", 0); sb_push("rst_rd", 0);
      step(3);
      sb_pop(32'(CronoActivo)); sb_pop(32'(Ring)); sb_pop(32'(RdValue));

      // ch0: load 3, release with Inicio, count 3,2,1 then ring
      Reset = 1'b1; ProgWe = 1'b1; ProgSel = 1'b0; ProgValue = 19'd3;
      step();
      ProgWe = 1'b0; ProgramarCrono[0] = 1'b0; InicioCrono[0] = 1'b1;
      sb_push("run0_activo", 1); sb_push("run0_rd3", 3);
      step(2);
      sb_pop(32'(CronoActivo[0])); sb_pop(32'(RdValue));
      for (int v = 2; v >= 0; v--) begin
         sb_push($sformatf("run0_rd%0d", v), 32'(v));
         to_tick(); step();
         sb_pop(32'(RdValue));
      end
      sb_push("done0_ring", 1); sb_push("done0_activo", 0);
      sb_pop(32'(Ring[0])); sb_pop(32'(CronoActivo[0]));

      // ring timeout after exactly RING_TICKS ticks, then IDLE with count 0
      sb_push("ring_t2", 1); sb_push("ring_t3_edge", 1); sb_push("ring_timeout", 0);
      to_tick(); to_tick(); step();
      sb_pop(32'(Ring[0]));
      to_tick();
      sb_pop(32'(Ring[0]));
      step();
      sb_pop(32'(Ring[0]));
      sb_push("idle0_no_restart", 0); sb_push("idle0_rd", 0);
      step(6);
      sb_pop(32'(CronoActivo[0])); sb_pop(32'(RdValue));

      // ch1 from 5, pause on a tick cycle, resume
      ProgSel = 1'b1; ProgWe = 1'b1; ProgValue = 19'd5;
      step();
      ProgWe = 1'b0; ProgramarCrono[1] = 1'b0; InicioCrono[1] = 1'b1;
      sb_push("run1_activo", 1); sb_push("run1_rd5", 5);
      step(2);
      sb_pop(32'(CronoActivo[1])); sb_pop(32'(RdValue));
      for (int v = 4; v >= 3; v--) begin
         sb_push($sformatf("run1_rd%0d", v), 32'(v));
         to_tick(); step();
         sb_pop(32'(RdValue));
      end
      to_pre_tick();
      InicioCrono[1] = 1'b0;
      sb_push("pause_rd", 3); sb_push("pause_activo", 0); sb_push("pause_hold", 3);
      step(2);
      sb_pop(32'(RdValue)); sb_pop(32'(CronoActivo[1]));
      to_tick(); to_tick(); step();
      sb_pop(32'(RdValue));
      InicioCrono[1] = 1'b1;
      sb_push("resume_rd", 2); sb_push("resume_activo", 1);
      to_tick(); step();
      sb_pop(32'(RdValue)); sb_pop(32'(CronoActivo[1]));

      // ch0 reprogrammed to 1 so both channels ring; ack silences only ch0
      ProgramarCrono[0] = 1'b1; ProgSel = 1'b0; ProgWe = 1'b1; ProgValue = 19'd1;
      step(2);
      ProgWe = 1'b0; ProgramarCrono[0] = 1'b0; ProgSel = 1'b1;
      sb_push("ind_rd1", 1); sb_push("ind_activo0", 1);
      to_tick(); step();
      sb_pop(32'(RdValue)); sb_pop(32'(CronoActivo[0]));
      sb_push("both_ring", 3);
      to_tick(); step();
      sb_pop(32'(Ring));
      RingAck = 2'b01;
      sb_push("ack0_ring", 2);
      step();
      RingAck = 2'b00;
      step();
      sb_pop(32'(Ring));

      // PROG clears ring; stray write while RUN ignored; PROG beats terminal count
      ProgramarCrono[1] = 1'b1; ProgWe = 1'b1; ProgValue = 19'd2;
      step(2);
      ProgWe = 1'b0;
      sb_push("prog_ring_clr", 0); sb_push("prog1_rd2", 2);
      step();
      sb_pop(32'(Ring)); sb_pop(32'(RdValue));
      ProgramarCrono[1] = 1'b0;
      step();
      to_tick();
      ProgWe = 1'b1; ProgValue = 19'd9;
      step();
      ProgWe = 1'b0;
      sb_push("we_ignored_rd", 1); sb_push("we_ignored_activo", 1);
      step();
      sb_pop(32'(RdValue)); sb_pop(32'(CronoActivo[1]));
      to_pre_tick();
      ProgramarCrono[1] = 1'b1;
      sb_push("prog_wins_ring", 0); sb_push("prog_wins_rd", 1); sb_push("prog_wins_activo", 0);
      step(2);
      sb_pop(32'(Ring)); sb_pop(32'(RdValue)); sb_pop(32'(CronoActivo));

      // reset mid-RUN on ch0, then prescaler phase restarts from 0
      ProgramarCrono[0] = 1'b1; ProgSel = 1'b0; ProgWe = 1'b1; ProgValue = 19'd7;
      step(2);
      ProgWe = 1'b0; ProgramarCrono[0] = 1'b0;
      sb_push("pre_rst_activo", 1);
      step(2);
      sb_pop(32'(CronoActivo[0]));
      Reset = 1'b0; ProgramarCrono = 2'b11;
      sb_push("midrst_activo", 0); sb_push("midrst_ring", 0); sb_push("midrst_rd", 0);
      step();
      sb_pop(32'(CronoActivo)); sb_pop(32'(Ring)); sb_pop(32'(RdValue));
      Reset = 1'b1; ProgWe = 1'b1; ProgValue = 19'd2;
      step();
      ProgWe = 1'b0; ProgramarCrono[0] = 1'b0;
      step();
      to_pre_tick();
      sb_push("post_rst_pre", 2); sb_push("post_rst_tick", 1);
      step();
      sb_pop(32'(RdValue));
      step();
      sb_pop(32'(RdValue));

      if (sb_q.size() != 0) begin
         n_chk++;
         n_err++;
         $display("FAIL sb_leftover: got %0d queued, required 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
